// File: rtl/alu_exec_if.sv
// Instruction, ALU-operand, write-back, debug and flag signals of alu_exec_stage.
// The stage connects through the slave modport; the instruction source and ALU side use master.
interface alu_exec_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 2,
    parameter int SEL_W      = 3
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [SEL_W-1:0]      instr_op;
    logic [REG_ADDR_W-1:0] instr_rd;
    logic [REG_ADDR_W-1:0] instr_rs1;
    logic [REG_ADDR_W-1:0] instr_rs2;
    logic [DATA_W-1:0]     instr_imm;
    logic                  instr_use_imm;
    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [SEL_W-1:0]      alu_sel;
    logic [DATA_W-1:0]     alu_out;
    logic                  res_valid;
    logic [REG_ADDR_W-1:0] res_rd;
    logic [DATA_W-1:0]     res_data;
    logic [REG_ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_data;
    logic                  flag_z;
    logic                  flag_n;

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, instr_use_imm,
        input  alu_out, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_sel, res_valid, res_rd, res_data, dbg_data,
        output flag_z, flag_n
    );

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, instr_use_imm,
        output alu_out, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_sel, res_valid, res_rd, res_data, dbg_data,
        input  flag_z, flag_n
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Multi-cycle execute stage (IDLE -> EXEC -> WB) feeding a combinational ALU and owning the register file.
// Define ALU_FLAGS_EN to build the zero/negative result flags; otherwise they are tied low.
module alu_exec_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 2,
    parameter int SEL_W      = 3
) (
    input logic        clk,
    input logic        reset,
    alu_exec_if.slave  bus
);
    localparam int DEPTH = 2 ** REG_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     rf_q [DEPTH];
    logic [DATA_W-1:0]     rf_d [DEPTH];
    logic [DATA_W-1:0]     alu_a_q, alu_a_d;
    logic [DATA_W-1:0]     alu_b_q, alu_b_d;
    logic [SEL_W-1:0]      alu_sel_q, alu_sel_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [REG_ADDR_W-1:0] res_rd_q, res_rd_d;
    logic [DATA_W-1:0]     res_data_q, res_data_d;

    logic                  instr_ready;
    logic                  res_valid;
    logic                  accept;
    logic [DATA_W-1:0]     rs1_data, rs2_data, dbg_rd_data;

    // Register 0 reads as zero regardless of what the array holds.
    assign rs1_data    = (bus.instr_rs1 == '0) ? '0 : rf_q[bus.instr_rs1];
    assign rs2_data    = (bus.instr_rs2 == '0) ? '0 : rf_q[bus.instr_rs2];
    assign dbg_rd_data = (bus.dbg_addr  == '0) ? '0 : rf_q[bus.dbg_addr];

    assign accept = instr_ready & bus.instr_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.instr_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        unique case (state_q)
            S_IDLE:  instr_ready = 1'b1;
            S_WB:    res_valid   = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rf_d       = rf_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rd_d       = rd_q;
        res_rd_d   = res_rd_q;
        res_data_d = res_data_q;
        if (accept) begin
            alu_a_d   = rs1_data;
            alu_b_d   = bus.instr_use_imm ? bus.instr_imm : rs2_data;
            alu_sel_d = bus.instr_op;
            rd_d      = bus.instr_rd;
        end
        if (state_q == S_EXEC) begin
            res_data_d = bus.alu_out;
            res_rd_d   = rd_q;
        end
        if ((state_q == S_WB) && (res_rd_q != '0)) begin
            rf_d[res_rd_q] = res_data_q;
        end
    end

    // NOTE: the register file is small and must read zero after reset, so it is reset like any flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_q       <= '{default: '0};
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rd_q       <= '0;
            res_rd_q   <= '0;
            res_data_q <= '0;
        end else begin
            rf_q       <= rf_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rd_q       <= rd_d;
            res_rd_q   <= res_rd_d;
            res_data_q <= res_data_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_n_q, flag_n_d;

    // Flags follow every write-back, including discarded writes to register 0.
    always_comb begin
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        if (state_q == S_WB) begin
            flag_z_d = (res_data_q == '0);
            flag_n_d = res_data_q[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign bus.flag_z = flag_z_q;
    assign bus.flag_n = flag_n_q;
`else
    assign bus.flag_z = 1'b0;
    assign bus.flag_n = 1'b0;
`endif

    assign bus.instr_ready = instr_ready;
    assign bus.res_valid   = res_valid;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_sel     = alu_sel_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.res_data    = res_data_q;
    assign bus.dbg_data    = dbg_rd_data;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized self-checking bench for alu_exec_stage against an instruction-level model
// (architectural register file + ALU function), plus the directed scenarios.
module tb_alu_exec_stage;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 2;
    localparam int SEL_W      = 3;
`ifdef ALU_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_accept = 0;

    logic [DATA_W-1:0] model_rf [4];
    logic              exp_z, exp_n;

    alu_exec_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) bus ();

    alu_exec_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External ALU stand-in: sel 1 = A+B, 2 = A-B, the rest are simple logic ops.
    function automatic logic [DATA_W-1:0] bench_alu(input logic [SEL_W-1:0] sel,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        case (sel)
            3'h0:    return a & b;
            3'h1:    return a + b;
            3'h2:    return a - b;
            3'h3:    return a | b;
            3'h4:    return a ^ b;
            3'h5:    return b;
            3'h6:    return a;
            default: return ~a;
        endcase
    endfunction

    assign bus.alu_out = bench_alu(bus.alu_sel, bus.alu_a, bus.alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [1:0] r);
        return (r == 2'd0) ? '0 : model_rf[r];
    endfunction

    task automatic check_rf_all();
        for (int r = 0; r < 4; r++) begin
            bus.dbg_addr = r[1:0];
            #1;
            check("dbg_rf", bus.dbg_data, model_read(r[1:0]));
        end
    endtask

    // Offers one instruction and follows it through to the return to IDLE.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [15:0] imm, input logic use_imm,
                             input bit hold_valid, input bit check_gap);
        logic [DATA_W-1:0] ea, eb, er;
        int waited;
        bus.instr_op      = op;
        bus.instr_rd      = rd;
        bus.instr_rs1     = rs1;
        bus.instr_rs2     = rs2;
        bus.instr_imm     = imm;
        bus.instr_use_imm = use_imm;
        bus.instr_valid   = 1'b1;
        waited = 0;
        while (!bus.instr_ready && waited < 10) begin
            step();
            waited++;
        end
        if (!bus.instr_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.instr_valid = 1'b0;
            return;
        end
        ea = model_read(rs1);
        eb = use_imm ? imm : model_read(rs2);
        er = bench_alu(op, ea, eb);

        step();
        if (check_gap) check("accept_gap", cyc - last_accept, 32'd3);
        last_accept = cyc;
        if (!hold_valid) bus.instr_valid = 1'b0;
        check("alu_a", bus.alu_a, ea);
        check("alu_b", bus.alu_b, eb);
        check("alu_sel", bus.alu_sel, op);
        check("ready_exec", bus.instr_ready, 1'b0);
        check("res_valid_exec", bus.res_valid, 1'b0);

        step();
        check("res_valid_wb", bus.res_valid, 1'b1);
        check("res_rd", bus.res_rd, rd);
        check("res_data", bus.res_data, er);
        check("ready_wb", bus.instr_ready, 1'b0);

        step();
        if (rd != 2'd0) model_rf[rd] = er;
        exp_z = (er == '0);
        exp_n = er[DATA_W-1];
        check("ready_idle", bus.instr_ready, 1'b1);
        check("res_valid_idle", bus.res_valid, 1'b0);
        check("flag_z", bus.flag_z, FLAGS_EN ? exp_z : 1'b0);
        check("flag_n", bus.flag_n, FLAGS_EN ? exp_n : 1'b0);
        check_rf_all();
    endtask

    task automatic reset_checks();
        check("rst_ready", bus.instr_ready, 1'b1);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_alu_a", bus.alu_a, 16'h0);
        check("rst_alu_b", bus.alu_b, 16'h0);
        check("rst_alu_sel", bus.alu_sel, 3'h0);
        check("rst_res_data", bus.res_data, 16'h0);
        check("rst_res_rd", bus.res_rd, 2'h0);
        check("rst_flag_z", bus.flag_z, 1'b0);
        check("rst_flag_n", bus.flag_n, 1'b0);
        check_rf_all();
    endtask

    initial begin
        bus.instr_valid   = 1'b0;
        bus.instr_op      = '0;
        bus.instr_rd      = '0;
        bus.instr_rs1     = '0;
        bus.instr_rs2     = '0;
        bus.instr_imm     = '0;
        bus.instr_use_imm = 1'b0;
        bus.dbg_addr      = '0;
        for (int r = 0; r < 4; r++) model_rf[r] = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        reset_checks();

        // Immediate load into r1, then r2, then register op into r3.
        run_instr(3'h1, 2'd1, 2'd0, 2'd0, 16'h0AB0, 1'b1, 1'b0, 1'b0);
        check("imm_load_const", bus.res_data, 16'h0AB0);
        run_instr(3'h1, 2'd2, 2'd0, 2'd0, 16'h01AC, 1'b1, 1'b0, 1'b0);
        run_instr(3'h1, 2'd3, 2'd1, 2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        check("reg_op_const", bus.res_data, 16'h0C5C);

        // r1 - r1 into r0: zero result, write discarded.
        run_instr(3'h2, 2'd0, 2'd1, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("r0_flag_z_const", bus.flag_z, FLAGS_EN);

        // Back-to-back with valid held; second uses the first's result.
        run_instr(3'h1, 2'd1, 2'd0, 2'd0, 16'h1234, 1'b1, 1'b1, 1'b0);
        run_instr(3'h1, 2'd2, 2'd1, 2'd1, 16'h0000, 1'b0, 1'b1, 1'b1);
        check("b2b_dep_const", bus.res_data, 16'h2468);
        run_instr(3'h2, 2'd3, 2'd2, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset while the instruction is in EXEC drops it.
        bus.instr_op      = 3'h1;
        bus.instr_rd      = 2'd1;
        bus.instr_rs1     = 2'd0;
        bus.instr_imm     = 16'hBEEF;
        bus.instr_use_imm = 1'b1;
        bus.instr_valid   = 1'b1;
        check("pre_rst_ready", bus.instr_ready, 1'b1);
        step();
        bus.instr_valid = 1'b0;
        check("exec_ready", bus.instr_ready, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int r = 0; r < 4; r++) model_rf[r] = '0;
        check("mid_rst_res_valid", bus.res_valid, 1'b0);
        reset_checks();
        step();
        check("post_rst_res_valid", bus.res_valid, 1'b0);
        check("post_rst_ready", bus.instr_ready, 1'b1);
        check_rf_all();

        run_instr(3'h1, 2'd2, 2'd0, 2'd0, 16'h8000, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
